// File: rtl/trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : trace_checker
// Description : Streaming checker for simulator trace lines, one ASCII
//               character per clock.
//
//               Register line : ^T@P: $R <= D#
//               Memory line   : ^T@P: *A <= D#
//               T, R : 1..TIME_DIGITS decimal digits
//               P, A, D : exactly HEX_DIGITS hex digits
//               Spaces are allowed after ':', after R/A, and after '<='.
//
//               When '#' completes a legal line, the line type, the field
//               checks and the field values are registered. format_type
//               and error_code are nonzero only during the following cycle.
//
// Ports       : clk         - clock, all state changes on the rising edge
//               reset       - synchronous, active-high reset
//               char        - ASCII character consumed this cycle
//               format_type - 00 none, 01 register line, 10 memory line
//               error_code  - {reg>31, addr bad, pc bad, time odd}
//               time_val    - T of the last valid line
//               pc_val      - P of the last valid line
//               addr_val    - A (memory line) or R (register line)
//               data_val    - D of the last valid line
//               line_count  - valid lines since reset, saturating
//
// Revision    : 1.0 - initial release
// ============================================================================
module trace_checker #(
    parameter int unsigned TIME_DIGITS = 4,
    parameter int unsigned HEX_DIGITS  = 8,
    parameter bit          ALLOW_UPPER = 1'b0,
    parameter logic [31:0] PC_MIN      = 32'h0000_3000,
    parameter logic [31:0] PC_MAX      = 32'h0000_6ffc,
    parameter logic [31:0] ADDR_MIN    = 32'h0000_0000,
    parameter logic [31:0] ADDR_MAX    = 32'h0000_2ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char,
    output logic [1:0]  format_type,
    output logic [3:0]  error_code,
    output logic [31:0] time_val,
    output logic [31:0] pc_val,
    output logic [31:0] addr_val,
    output logic [31:0] data_val,
    output logic [15:0] line_count
);

    // ------------------------------------------------------------------
    // State encoding: each state names the last token accepted
    // ------------------------------------------------------------------
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CARET  = 4'd1;
    localparam logic [3:0] S_TIME   = 4'd2;
    localparam logic [3:0] S_AT     = 4'd3;
    localparam logic [3:0] S_PC     = 4'd4;
    localparam logic [3:0] S_COLON  = 4'd5;
    localparam logic [3:0] S_DOLLAR = 4'd6;
    localparam logic [3:0] S_STAR   = 4'd7;
    localparam logic [3:0] S_REG    = 4'd8;
    localparam logic [3:0] S_ADDR   = 4'd9;
    localparam logic [3:0] S_SPC    = 4'd10;
    localparam logic [3:0] S_LT     = 4'd11;
    localparam logic [3:0] S_EQ     = 4'd12;
    localparam logic [3:0] S_DATA   = 4'd13;
    localparam logic [3:0] S_DONE   = 4'd14;

    localparam logic [7:0] C_CH_CARET  = 8'h5e;
    localparam logic [7:0] C_CH_AT     = 8'h40;
    localparam logic [7:0] C_CH_COLON  = 8'h3a;
    localparam logic [7:0] C_CH_DOLLAR = 8'h24;
    localparam logic [7:0] C_CH_STAR   = 8'h2a;
    localparam logic [7:0] C_CH_SPACE  = 8'h20;
    localparam logic [7:0] C_CH_LT     = 8'h3c;
    localparam logic [7:0] C_CH_EQ     = 8'h3d;
    localparam logic [7:0] C_CH_HASH   = 8'h23;

    localparam logic [3:0] C_TD = TIME_DIGITS[3:0];
    localparam logic [3:0] C_HD = HEX_DIGITS[3:0];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]  r_state;
    logic [3:0]  r_cnt;      // digits accepted in the current field
    logic        r_is_mem;   // line type chosen at '$' / '*'
    logic [31:0] r_time;
    logic [31:0] r_pc;
    logic [31:0] r_addr;     // holds R for register lines, A for memory lines
    logic [31:0] r_data;

    // ------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------
    logic        w_is_digit;
    logic        w_is_lhex;
    logic        w_is_uhex;
    logic        w_is_hex;
    logic        w_is_space;
    logic [3:0]  w_nib;

    assign w_is_digit = (char >= 8'h30) && (char <= 8'h39);
    assign w_is_lhex  = (char >= 8'h61) && (char <= 8'h66);
    assign w_is_uhex  = ALLOW_UPPER && (char >= 8'h41) && (char <= 8'h46);
    assign w_is_hex   = w_is_digit || w_is_lhex || w_is_uhex;
    assign w_is_space = (char == C_CH_SPACE);
    // Letters a-f / A-F share low nibbles 1..6, so +9 yields 10..15.
    assign w_nib      = w_is_digit ? char[3:0] : (char[3:0] + 4'd9);

    logic w_time_room;
    logic w_hex_room;
    logic w_hex_full;

    assign w_time_room = (r_cnt < C_TD);
    assign w_hex_room  = (r_cnt < C_HD);
    assign w_hex_full  = (r_cnt == C_HD);

    // ------------------------------------------------------------------
    // Next-state logic. Anything not explicitly legal falls back to the
    // recovery target: CARET on '^', IDLE otherwise.
    // ------------------------------------------------------------------
    logic [3:0] w_next;

    always_comb begin
        w_next = (char == C_CH_CARET) ? S_CARET : S_IDLE;
        case (r_state)
            S_CARET: begin
                if (w_is_digit) w_next = S_TIME;
            end
            S_TIME: begin
                if (w_is_digit && w_time_room)  w_next = S_TIME;
                else if (char == C_CH_AT)       w_next = S_AT;
            end
            S_AT: begin
                if (w_is_hex) w_next = S_PC;
            end
            S_PC: begin
                if (w_is_hex && w_hex_room)                   w_next = S_PC;
                else if ((char == C_CH_COLON) && w_hex_full)  w_next = S_COLON;
            end
            S_COLON: begin
                if (w_is_space)                w_next = S_COLON;
                else if (char == C_CH_DOLLAR)  w_next = S_DOLLAR;
                else if (char == C_CH_STAR)    w_next = S_STAR;
            end
            S_DOLLAR: begin
                if (w_is_digit) w_next = S_REG;
            end
            S_REG: begin
                if (w_is_digit && w_time_room)  w_next = S_REG;
                else if (w_is_space)            w_next = S_SPC;
                else if (char == C_CH_LT)       w_next = S_LT;
            end
            S_STAR: begin
                if (w_is_hex) w_next = S_ADDR;
            end
            S_ADDR: begin
                if (w_is_hex && w_hex_room)                w_next = S_ADDR;
                else if (w_is_space && w_hex_full)         w_next = S_SPC;
                else if ((char == C_CH_LT) && w_hex_full)  w_next = S_LT;
            end
            S_SPC: begin
                if (w_is_space)             w_next = S_SPC;
                else if (char == C_CH_LT)   w_next = S_LT;
            end
            S_LT: begin
                if (char == C_CH_EQ) w_next = S_EQ;
            end
            S_EQ: begin
                if (w_is_space)     w_next = S_EQ;
                else if (w_is_hex)  w_next = S_DATA;
            end
            S_DATA: begin
                if (w_is_hex && w_hex_room)                  w_next = S_DATA;
                else if ((char == C_CH_HASH) && w_hex_full)  w_next = S_DONE;
            end
            default: begin
                // IDLE and DONE only leave through the recovery target.
            end
        endcase
    end

    // Staying in a digit-field state means one more digit; entering it
    // means the first one.
    logic [3:0] w_cnt_next;
    assign w_cnt_next = (w_next == r_state) ? (r_cnt + 4'd1) : 4'd1;

    logic [31:0] w_time_acc;
    logic [31:0] w_reg_acc;
    logic [31:0] w_pc_acc;
    logic [31:0] w_addr_acc;
    logic [31:0] w_data_acc;

    assign w_time_acc = (r_time * 32'd10) + {28'd0, w_nib};
    assign w_reg_acc  = (r_addr * 32'd10) + {28'd0, w_nib};
    assign w_pc_acc   = {r_pc[27:0], w_nib};
    assign w_addr_acc = {r_addr[27:0], w_nib};
    assign w_data_acc = {r_data[27:0], w_nib};

    // ------------------------------------------------------------------
    // Field checks. The range test subtracts the lower bound so that a
    // single unsigned compare covers both ends (values below MIN wrap to
    // large numbers).
    // ------------------------------------------------------------------
    logic       w_pc_bad;
    logic       w_addr_bad;
    logic       w_reg_bad;
    logic [3:0] w_err;

    assign w_pc_bad   = (r_pc[1:0] != 2'b00) ||
                        ((r_pc - PC_MIN) > (PC_MAX - PC_MIN));
    assign w_addr_bad = (r_addr[1:0] != 2'b00) ||
                        ((r_addr - ADDR_MIN) > (ADDR_MAX - ADDR_MIN));
    assign w_reg_bad  = (r_addr > 32'd31);
    assign w_err      = {(~r_is_mem) & w_reg_bad,
                         r_is_mem & w_addr_bad,
                         w_pc_bad,
                         r_time[0]};

    // ------------------------------------------------------------------
    // State, accumulators and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_is_mem    <= 1'b0;
            r_time      <= 32'd0;
            r_pc        <= 32'd0;
            r_addr      <= 32'd0;
            r_data      <= 32'd0;
            format_type <= 2'b00;
            error_code  <= 4'b0000;
            time_val    <= 32'd0;
            pc_val      <= 32'd0;
            addr_val    <= 32'd0;
            data_val    <= 32'd0;
            line_count  <= 16'd0;
        end else begin
            r_state     <= w_next;
            format_type <= 2'b00;
            error_code  <= 4'b0000;
            case (w_next)
                S_CARET: begin
                    // Fresh line (or restart): drop any partial fields.
                    r_cnt    <= 4'd0;
                    r_is_mem <= 1'b0;
                    r_time   <= 32'd0;
                    r_pc     <= 32'd0;
                    r_addr   <= 32'd0;
                    r_data   <= 32'd0;
                end
                S_TIME: begin
                    r_time <= w_time_acc;
                    r_cnt  <= w_cnt_next;
                end
                S_PC: begin
                    r_pc  <= w_pc_acc;
                    r_cnt <= w_cnt_next;
                end
                S_DOLLAR: r_is_mem <= 1'b0;
                S_STAR:   r_is_mem <= 1'b1;
                S_REG: begin
                    r_addr <= w_reg_acc;
                    r_cnt  <= w_cnt_next;
                end
                S_ADDR: begin
                    r_addr <= w_addr_acc;
                    r_cnt  <= w_cnt_next;
                end
                S_DATA: begin
                    r_data <= w_data_acc;
                    r_cnt  <= w_cnt_next;
                end
                S_DONE: begin
                    format_type <= r_is_mem ? 2'b10 : 2'b01;
                    error_code  <= w_err;
                    time_val    <= r_time;
                    pc_val      <= r_pc;
                    addr_val    <= r_addr;
                    data_val    <= r_data;
                    if (line_count != 16'hffff) begin
                        line_count <= line_count + 16'd1;
                    end
                end
                default: begin
                    // Separator states carry no field data.
                end
            endcase
        end
    end

endmodule
`default_nettype wire
